// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with register-array storage, registered status
// flags, occupancy count, overflow/underflow pulses and a selectable read mode
// (standard registered read or first-word-fall-through).
module sync_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance looks only at the registered flags, so a pop cannot make
    // room for a write in the same cycle (and vice versa).
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign data_count = count;

    // Next occupancy; simultaneous accepted read and write cancel out.
    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and flags; flags derive from the next count so they
    // always agree with data_count on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is shown continuously; rd_en pops what is displayed.
        assign rd_data = mem[rd_ptr];
    end else begin : g_std
        logic [DATA_W-1:0] rd_q;

        // Registered read: data appears one edge after an accepted read.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= mem[rd_ptr];
            end
        end

        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int DEP = 256;
    localparam int AF  = DEP - 2;
    localparam int AE  = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   data_count;

    logic          f_wr_en = 1'b0;
    logic [DW-1:0] f_wr_data = '0;
    logic          f_rd_en = 1'b0;
    logic [DW-1:0] f_rd_data;
    logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [AW:0]   f_data_count;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    sync_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1'b0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_std (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .data_count(data_count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1'b1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .data_count(f_data_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial begin
        if (!(0 < AE && AE < AF && AF <= DEP))
            $fatal(1, "illegal threshold parameters");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rd;
        int            cnt;
        logic          emp;
        logic          aemp;
        logic          ovf;
        logic          udf;
        logic [DW-1:0] dat;
    } vec_t;

    vec_t vecs[11];
    logic [DW-1:0] q[$];

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[4]  = '{1'b1, 8'h44, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44};
        vecs[8]  = '{1'b1, 8'h55, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55};

        // reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst count", 32'(data_count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst aempty", 32'(almost_empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst afull", 32'(almost_full), 0);
        chk("rst ovf", 32'(overflow), 0);
        chk("rst udf", 32'(underflow), 0);
        chk("rst rd_data", 32'(rd_data), 0);
        sys_rst_n = 1'b1;
        cyc();

        // fill 0..255
        for (int k = 0; k < DEP; k++) begin
            wr_en = 1'b1;
            wr_data = 8'(k);
            cyc();
            chk($sformatf("fill%0d count", k), 32'(data_count), 32'(k + 1));
            chk($sformatf("fill%0d afull", k), 32'(almost_full), 32'((k + 1) >= AF));
            chk($sformatf("fill%0d full", k), 32'(full), 32'((k + 1) == DEP));
        end

        // write held while full
        wr_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("ovf%0d pulse", k), 32'(overflow), 1);
            chk($sformatf("ovf%0d count", k), 32'(data_count), DEP);
        end

        // simultaneous at full: only the read goes through
        rd_en = 1'b1;
        cyc();
        chk("fullrw count", 32'(data_count), DEP - 1);
        chk("fullrw ovf", 32'(overflow), 1);
        chk("fullrw full", 32'(full), 0);
        chk("fullrw data", 32'(rd_data), 0);

        // drain
        wr_en = 1'b0;
        for (int j = 1; j < DEP; j++) begin
            cyc();
            chk($sformatf("drain%0d data", j), 32'(rd_data), 32'(j));
            chk($sformatf("drain%0d count", j), 32'(data_count), 32'(DEP - 1 - j));
            chk($sformatf("drain%0d aempty", j), 32'(almost_empty), 32'((DEP - 1 - j) <= AE));
            chk($sformatf("drain%0d empty", j), 32'(empty), 32'(j == DEP - 1));
            if (j == 1) chk("ovf clear", 32'(overflow), 0);
        end

        // read while empty
        cyc();
        chk("udf pulse", 32'(underflow), 1);
        chk("udf data", 32'(rd_data), 32'hFF);
        chk("udf count", 32'(data_count), 0);
        rd_en = 1'b0;
        cyc();
        chk("udf clear", 32'(underflow), 0);

        // table-driven vectors
        for (int i = 0; i < 11; i++) begin
            wr_en = vecs[i].wr;
            wr_data = vecs[i].wd;
            rd_en = vecs[i].rd;
            cyc();
            chk($sformatf("vec%0d count", i), 32'(data_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("vec%0d aempty", i), 32'(almost_empty), 32'(vecs[i].aemp));
            chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d udf", i), 32'(underflow), 32'(vecs[i].udf));
            if (vecs[i].dat != 8'hFF)
                chk($sformatf("vec%0d data", i), 32'(rd_data), 32'(vecs[i].dat));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // steady state at count 10
        q.delete();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h60 + i);
            q.push_back(wr_data);
            cyc();
        end
        chk("pre10 count", 32'(data_count), 10);
        rd_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [DW-1:0] e;
            wr_data = 8'(8'h80 + i);
            e = q.pop_front();
            q.push_back(wr_data);
            cyc();
            chk($sformatf("rw10_%0d count", i), 32'(data_count), 10);
            chk($sformatf("rw10_%0d data", i), 32'(rd_data), 32'(e));
        end
        wr_en = 1'b0;

        // random interleave against a queue model
        for (int i = 0; i < 1000; i++) begin
            logic w, r, wa, ra, was_empty;
            logic [DW-1:0] e;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            wr_en = w;
            rd_en = r;
            wr_data = 8'($urandom_range(0, 255));
            was_empty = (q.size() == 0);
            wa = w && (q.size() < DEP);
            ra = r && !was_empty;
            e = 8'h00;
            if (ra) e = q.pop_front();
            if (wa) q.push_back(wr_data);
            cyc();
            chk($sformatf("rnd%0d count", i), 32'(data_count), 32'(q.size()));
            chk($sformatf("rnd%0d udf", i), 32'(underflow), 32'(r && was_empty));
            if (ra) chk($sformatf("rnd%0d data", i), 32'(rd_data), 32'(e));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        while (q.size() > 0) begin
            logic [DW-1:0] e;
            rd_en = 1'b1;
            e = q.pop_front();
            cyc();
            chk("flush data", 32'(rd_data), 32'(e));
        end
        rd_en = 1'b0;
        cyc();
        chk("flush empty", 32'(empty), 1);

        // asynchronous reset at count 37
        for (int i = 0; i < 37; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i + 1);
            cyc();
        end
        wr_en = 1'b0;
        chk("pre rst count", 32'(data_count), 37);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("arst count", 32'(data_count), 0);
        chk("arst empty", 32'(empty), 1);
        chk("arst aempty", 32'(almost_empty), 1);
        chk("arst full", 32'(full), 0);
        chk("arst afull", 32'(almost_full), 0);
        chk("arst rd_data", 32'(rd_data), 0);
        chk("arst ovf", 32'(overflow), 0);
        chk("arst udf", 32'(underflow), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc();
        wr_en = 1'b1;
        wr_data = 8'h11;
        cyc();
        wr_en = 1'b0;
        chk("post rst count", 32'(data_count), 1);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("post rst data", 32'(rd_data), 32'h11);
        chk("post rst empty", 32'(empty), 1);

        // first-word-fall-through instance
        chk("fwft rst empty", 32'(f_empty), 1);
        f_wr_en = 1'b1;
        f_wr_data = 8'hA5;
        cyc();
        f_wr_en = 1'b0;
        chk("fwft show", 32'(f_rd_data), 32'hA5);
        chk("fwft empty0", 32'(f_empty), 0);
        chk("fwft count1", 32'(f_data_count), 1);
        cyc();
        chk("fwft hold", 32'(f_rd_data), 32'hA5);
        f_rd_en = 1'b1;
        cyc();
        f_rd_en = 1'b0;
        chk("fwft pop empty", 32'(f_empty), 1);
        chk("fwft pop count", 32'(f_data_count), 0);
        f_wr_en = 1'b1;
        f_wr_data = 8'h01;
        cyc();
        f_wr_data = 8'h02;
        cyc();
        f_wr_en = 1'b0;
        chk("fwft head1", 32'(f_rd_data), 32'h01);
        f_rd_en = 1'b1;
        cyc();
        chk("fwft head2", 32'(f_rd_data), 32'h02);
        chk("fwft count after pop", 32'(f_data_count), 1);
        cyc();
        f_rd_en = 1'b0;
        chk("fwft final empty", 32'(f_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
